// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification,
// centre sampling of each data bit and stop-bit check with break handling.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxout,
    output logic                 rxdone,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rxout;
    logic                 r_rxdone;
    logic                 r_frame_err;
    logic                 r_busy;

    // Synchroniser resets to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make r_rx_s take the previous r_rx_meta, giving a true two-stage pipe.
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rxout     <= '0;
            r_rxdone    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each strobe lasts exactly one clock.
            r_rxdone    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_rxout  <= r_shift;
                            r_rxdone <= 1'b1;
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line stays here; only a return to idle re-arms the receiver.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rxout     = r_rxout;
    assign rxdone    = r_rxdone;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a driver serialises frames and queues the
// expected outcome; a monitor pops and compares on every rxdone/frame_err pulse.
module tb_uart_receiver;

    localparam int CPB    = 16;
    localparam int DB     = 8;
    localparam int BIT_NS = CPB * 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [DB-1:0] rxout;
    logic          rxdone;
    logic          frame_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
        int            start_cyc;
        bit            gap_chk;
    } exp_t;

    exp_t          exp_q[$];
    logic [DB-1:0] last_good = '0;
    int            prev_done_cyc = 0;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rxout     (rxout),
        .rxdone    (rxdone),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Line sequence for one frame: start 0, data LSB first, stop bit.
    task automatic drive_frame(input logic [DB-1:0] data, input logic stop_bit,
                               input int nbits, input int bit_ns);
        logic [DB+1:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            #(bit_ns);
        end
    endtask

    // Expected outcome from the frame rules: good stop -> byte, low stop -> error.
    task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit,
                              input int bit_ns, input bit gap_chk);
        exp_t e;
        e.is_err    = !stop_bit;
        e.data      = data;
        e.start_cyc = cyc;
        e.gap_chk   = gap_chk;
        exp_q.push_back(e);
        drive_frame(data, stop_bit, DB + 2, bit_ns);
    endtask

    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && (rxdone || frame_err)) begin
            check("pulse_exclusive", rxdone & frame_err, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: rxdone=%0b frame_err=%0b expected no pulse (t=%0t)",
                         rxdone, frame_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_err", frame_err, e.is_err);
                check_range("latency", cyc - e.start_cyc, 153, 157);
                if (e.is_err) begin
                    check("rxout_hold_on_err", rxout, last_good);
                end else begin
                    check("rxout", rxout, e.data);
                    if (e.gap_chk) check_range("b2b_gap", cyc - prev_done_cyc, 159, 161);
                    last_good     = e.data;
                    prev_done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rxout", rxout, 0);
        check("rst_rxdone", rxdone, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0xA5 at nominal rate.
        align();
        send_frame(8'hA5, 1'b1, BIT_NS, 1'b0);
        #(BIT_NS);
        wait_drain("drain_a5", 300);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        align();
        send_frame(8'h00, 1'b1, BIT_NS, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_NS, 1'b1);
        #(BIT_NS);
        wait_drain("drain_b2b", 300);

        // 5-cycle glitch: busy rises, then receiver gives up silently.
        align();
        rx = 1'b0;
        #45;
        check("glitch_busy_high", busy, 1'b1);
        #5;
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_rxout_hold", rxout, last_good);

        // Framing error, long break, then a good frame.
        align();
        send_frame(8'h3C, 1'b0, BIT_NS, 1'b0);
        rx = 1'b0;
        #(40 * BIT_NS);
        check("break_busy", busy, 1'b1);
        check("break_rxout_hold", rxout, last_good);
        rx = 1'b1;
        #(2 * BIT_NS);
        align();
        send_frame(8'h81, 1'b1, BIT_NS, 1'b0);
        #(BIT_NS);
        wait_drain("drain_err", 300);

        // Asynchronous reset in the middle of the data bits.
        align();
        drive_frame(8'h77, 1'b1, 5, BIT_NS);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rxout", rxout, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rxdone", rxdone, 0);
        check("async_rst_frame_err", frame_err, 0);
        rx = 1'b1;
        last_good = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        align();
        send_frame(8'h5A, 1'b1, BIT_NS, 1'b0);
        #(BIT_NS);
        wait_drain("drain_5a", 300);

        // Random bytes at nominal, -3% and +3% bit periods.
        for (int i = 0; i < 24; i++) begin
            int            sel;
            int            bns;
            logic [DB-1:0] d;
            sel = int'($urandom_range(2, 0));
            bns = (sel == 0) ? 155 : (sel == 1) ? 160 : 165;
            d   = DB'($urandom);
            align();
            send_frame(d, 1'b1, bns, 1'b0);
            #(int'($urandom_range(BIT_NS, 10)));
        end
        wait_drain("drain_rand", 400);
        repeat (20) @(negedge clk);
        check("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout: simulation did not finish expected done");
        $fatal(1, "timeout");
    end

endmodule
